// File: rtl/pid_un_pwm.sv
// rtl/pid_un_pwm.sv - u(n) to dead-time-protected complementary PWM actuator stage
//
// Takes the signed u(n) word from pid_simple, arithmetic-shifts and clamps it
// into a shadow duty register, and loads that duty at period boundaries so the
// power stage never sees a truncated pulse. The raw PWM comparison is split into
// a complementary high/low pair with a dead-time gap after every raw edge.
//
// Ports:
//   i_clk          clock, all logic on the rising edge
//   i_rst_n        asynchronous active-low reset
//   i_un           signed u(n) sample
//   i_valid        one-cycle strobe qualifying i_un
//   i_period       PWM period minus one (P = i_period + 1 clocks)
//   i_enable       run the PWM while high
//   o_pwm_h        high-side drive
//   o_pwm_l        low-side drive
//   o_duty         active duty (0..P)
//   o_sat_hi       last sample clamped to P (held until next i_valid)
//   o_sat_lo       last sample clamped to 0 (held until next i_valid)
//   o_period_start one-cycle pulse for each period start while enabled
//   o_overrun      one-cycle pulse when a pending sample is overwritten

module pid_un_pwm #(
  parameter int CNT_W    = 12,
  parameter int UN_SHIFT = 8,
  parameter int DEADTIME = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [31:0]      i_un,
  input  logic             i_valid,
  input  logic [CNT_W-1:0] i_period,
  input  logic             i_enable,
  output logic             o_pwm_h,
  output logic             o_pwm_l,
  output logic [CNT_W:0]   o_duty,
  output logic             o_sat_hi,
  output logic             o_sat_lo,
  output logic             o_period_start,
  output logic             o_overrun
);

  localparam int DT_W = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;
  localparam logic [DT_W-1:0]  DT_LOAD = DT_W'(DEADTIME);
  localparam logic [DT_W-1:0]  DT_ONE  = DT_W'(1);
  localparam logic [CNT_W:0]   LIM_ONE = (CNT_W + 1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_active;
  logic [CNT_W:0]   shadow;
  logic [CNT_W:0]   duty_active;
  logic             pending;
  logic             raw_q;
  logic             en_q;
  logic [DT_W-1:0]  dt_cnt;

  logic signed [31:0] s;
  logic signed [32:0] s_ext;
  logic signed [32:0] lim_ext;
  logic [CNT_W:0]     lim_cur;
  logic [CNT_W:0]     lim_new;
  logic [CNT_W:0]     sample_val;
  logic [CNT_W:0]     load_val;
  logic               sample_hi;
  logic               sample_lo;
  logic               wrap;
  logic               load;
  logic               raw;
  logic               en_rise;
  logic               force_low;
  logic [DT_W-1:0]    dt_next;

  always_comb begin
    s       = $signed(i_un) >>> UN_SHIFT;
    s_ext   = {s[31], s};
    // Samples are clamped against the period currently running; a later
    // period change is handled by re-clamping at load time.
    lim_cur = {1'b0, period_active} + LIM_ONE;
    lim_ext = {{(32 - CNT_W){1'b0}}, lim_cur};
    lim_new = {1'b0, i_period} + LIM_ONE;

    sample_lo = s[31];
    sample_hi = !s[31] && (s_ext > lim_ext);
    if (sample_lo) begin
      sample_val = '0;
    end else if (sample_hi) begin
      sample_val = lim_cur;
    end else begin
      sample_val = s[CNT_W:0];
    end

    load_val = (shadow > lim_new) ? lim_new : shadow;

    wrap = i_enable && (cnt == period_active);
    // While disabled every cycle behaves as a boundary, so period and duty
    // track their sources without waiting for a wrap.
    load = wrap || !i_enable;

    raw     = i_enable && ({1'b0, cnt} < duty_active);
    en_rise = i_enable && !en_q;

    // Any raw edge (or a fresh enable) restarts the gap; both outputs stay
    // low while the gap counter is non-zero, which also swallows short pulses.
    if ((raw != raw_q) || en_rise) begin
      dt_next = DT_LOAD;
    end else if (dt_cnt != '0) begin
      dt_next = dt_cnt - DT_ONE;
    end else begin
      dt_next = '0;
    end
    force_low = (dt_next != '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt            <= '0;
      period_active  <= '0;
      shadow         <= '0;
      duty_active    <= '0;
      pending        <= 1'b0;
      raw_q          <= 1'b0;
      en_q           <= 1'b0;
      dt_cnt         <= '0;
      o_pwm_h        <= 1'b0;
      o_pwm_l        <= 1'b0;
      o_sat_hi       <= 1'b0;
      o_sat_lo       <= 1'b0;
      o_period_start <= 1'b0;
      o_overrun      <= 1'b0;
    end else begin
      en_q   <= i_enable;
      raw_q  <= raw;
      dt_cnt <= dt_next;

      if (!i_enable || wrap) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end

      if (load) begin
        period_active <= i_period;
      end
      if (load && pending) begin
        duty_active <= load_val;
      end

      // A sample arriving on a load cycle becomes pending for the next
      // period; the previous shadow is the one loaded now.
      if (i_valid) begin
        shadow   <= sample_val;
        o_sat_hi <= sample_hi;
        o_sat_lo <= sample_lo;
        pending  <= 1'b1;
      end else if (load) begin
        pending <= 1'b0;
      end

      o_overrun      <= i_valid && pending && !load;
      o_period_start <= i_enable && (cnt == '0);
      o_pwm_h        <= i_enable && !force_low && raw;
      o_pwm_l        <= i_enable && !force_low && !raw;
    end
  end

  assign o_duty = duty_active;

endmodule

// File: tb/tb_pid_un_pwm.sv
// tb/tb_pid_un_pwm.sv - scoreboard bench for pid_un_pwm

module tb_pid_un_pwm;

  localparam int CNT_W    = 8;
  localparam int UN_SHIFT = 4;
  localparam int DT       = 2;

  logic             clk;
  logic             rst_n;
  logic [31:0]      un;
  logic             valid;
  logic [CNT_W-1:0] period;
  logic             enable;
  logic             pwm_h;
  logic             pwm_l;
  logic [CNT_W:0]   duty;
  logic             sat_hi;
  logic             sat_lo;
  logic             period_start;
  logic             overrun;

  pid_un_pwm #(
    .CNT_W   (CNT_W),
    .UN_SHIFT(UN_SHIFT),
    .DEADTIME(DT)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_un          (un),
    .i_valid       (valid),
    .i_period      (period),
    .i_enable      (enable),
    .o_pwm_h       (pwm_h),
    .o_pwm_l       (pwm_l),
    .o_duty        (duty),
    .o_sat_hi      (sat_hi),
    .o_sat_lo      (sat_lo),
    .o_period_start(period_start),
    .o_overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int hi;
    int lo;
    int ovr;
  } flag_t;

  typedef struct {
    int duty;
    int h;
    int l;
    int len;
  } load_t;

  flag_t fq[$];
  load_t lq[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int shifted(input logic [31:0] u);
    int s;
    s = $signed(u) >>> UN_SHIFT;
    return s;
  endfunction

  function automatic int clamp_to(input int s, input int plim);
    if (s < 0) return 0;
    if (s > plim) return plim;
    return s;
  endfunction

  function automatic int exp_h(input int d, input int p);
    if (d <= 0) return 0;
    if (d >= p) return p;
    if (d <= DT) return 0;
    return d - DT;
  endfunction

  function automatic int exp_l(input int d, input int p);
    if (d >= p) return 0;
    if (d <= 0) return p;
    if (p - d <= DT) return 0;
    return p - d - DT;
  endfunction

  // Drive one sample; flags are checked at t+1, and if the sample is the one
  // expected to reach duty_active its steady-period expectation is queued.
  task automatic send(input logic [31:0] u, input int plim_now, input int plim_load,
                      input int exp_ovr, input bit will_load);
    flag_t f;
    load_t e;
    int s;
    s     = shifted(u);
    f.hi  = (s > plim_now) ? 1 : 0;
    f.lo  = (s < 0) ? 1 : 0;
    f.ovr = exp_ovr;
    fq.push_back(f);
    if (will_load) begin
      e.duty = clamp_to(clamp_to(s, plim_now), plim_load);
      e.h    = exp_h(e.duty, plim_load);
      e.l    = exp_l(e.duty, plim_load);
      e.len  = plim_load;
      lq.push_back(e);
    end
    un    = u;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    f = fq.pop_front();
    chk("sat_hi", int'(sat_hi), f.hi);
    chk("sat_lo", int'(sat_lo), f.lo);
    chk("overrun", int'(overrun), f.ovr);
  endtask

  task automatic wait_ps();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!period_start && k < 400);
    chk("period_start_seen", int'(period_start), 1);
  endtask

  // Called on a period_start cycle; returns at the next one.
  task automatic measure(output int h, output int l, output int both, output int len);
    h = 0; l = 0; both = 0; len = 0;
    do begin
      h    += int'(pwm_h);
      l    += int'(pwm_l);
      both += int'(pwm_h & pwm_l);
      len++;
      @(negedge clk);
    end while (!period_start && len < 400);
  endtask

  task automatic check_load(input bit steady, output int h_first);
    load_t e;
    int h, l, both, len;
    h_first = 0;
    if (lq.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
      return;
    end
    e = lq.pop_front();
    chk("duty", int'(duty), e.duty);
    measure(h, l, both, len);
    h_first = h;
    if (steady) measure(h, l, both, len);
    chk("pwm_h_cycles", h, e.h);
    chk("pwm_l_cycles", l, e.l);
    chk("both_high", both, 0);
    chk("period_len", len, e.len);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_h"}, int'(pwm_h), 0);
    chk({tag, "_l"}, int'(pwm_l), 0);
    chk({tag, "_duty"}, int'(duty), 0);
    chk({tag, "_sat_hi"}, int'(sat_hi), 0);
    chk({tag, "_sat_lo"}, int'(sat_lo), 0);
    chk({tag, "_ps"}, int'(period_start), 0);
    chk({tag, "_ovr"}, int'(overrun), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int h1;
    rst_n  = 1'b0;
    enable = 1'b1;
    period = 8'd99;
    valid  = 1'b0;
    un     = '0;

    repeat (3) @(negedge clk);
    check_all_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_h", int'(pwm_h), 0);
    chk("rel_l", int'(pwm_l), 0);
    repeat (4) @(negedge clk);
    wait_ps();

    // nominal s=50
    send(32'h0000_0320, 100, 100, 0, 1);
    wait_ps();
    check_load(1, h1);

    // negative clamp
    send(32'hFFFF_FF00, 100, 100, 0, 1);
    wait_ps();
    check_load(1, h1);

    // positive clamp, first period shows the initial dead time
    send(32'h0000_1000, 100, 100, 0, 1);
    wait_ps();
    check_load(1, h1);
    chk("h_first_full", h1, 100 - DT);

    // overrun: two samples in one period, newest wins
    send(32'h0000_0100, 100, 100, 0, 0);
    repeat (5) @(negedge clk);
    send(32'h0000_0200, 100, 100, 1, 1);
    wait_ps();
    check_load(1, h1);

    // sample on the wrap cycle while another is pending
    send(32'h0000_0300, 100, 100, 0, 1);
    repeat (97) @(negedge clk);
    send(32'h0000_0500, 100, 100, 0, 1);
    chk("wrap_duty", int'(duty), lq[0].duty);
    wait_ps();
    check_load(0, h1);
    check_load(1, h1);

    // period shrinks to 50 with duty 80 pending: re-clamped at load
    send(32'h0000_0500, 100, 50, 0, 1);
    repeat (10) @(negedge clk);
    period = 8'd49;
    wait_ps();
    check_load(1, h1);
    chk("h_first_p50", h1, 50 - DT);

    // disable at cnt=30
    repeat (29) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("dis_h", int'(pwm_h), 0);
    chk("dis_l", int'(pwm_l), 0);
    period = 8'd99;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("dis_ps", int'(period_start), 0);
    end
    send(32'h0000_0140, 100, 100, 0, 1);
    @(negedge clk);
    chk("dis_duty", int'(duty), lq[0].duty);
    chk("dis_h2", int'(pwm_h), 0);
    chk("dis_l2", int'(pwm_l), 0);

    // re-enable
    enable = 1'b1;
    @(negedge clk);
    chk("en_ps", int'(period_start), 1);
    chk("en_h", int'(pwm_h), 0);
    chk("en_l", int'(pwm_l), 0);
    check_load(1, h1);

    // asynchronous reset mid-period with the high side active
    repeat (5) @(negedge clk);
    chk("pre_rst_h", int'(pwm_h), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("arst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_rel_h", int'(pwm_h), 0);
    chk("arst_rel_l", int'(pwm_l), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
